// File: rtl/arith_result_fifo.sv
// arith_result_fifo: captures ALU results with {V,N,Z,C} flags in a circular FIFO behind valid/ready.
// Define ARITH_RES_STATS_EN to add saturating carry/overflow push counters.
module arith_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               F,
  input  logic                     Cout,
  input  logic [2:0]               op,
  input  logic                     a_msb,
  input  logic                     b_msb,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_f,
  output logic [3:0]               out_flags,
  output logic [2:0]               out_op,
  output logic [$clog2(DEPTH):0]   count
`ifdef ARITH_RES_STATS_EN
  ,
  output logic [7:0]               carry_cnt,
  output logic [7:0]               ovf_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [10:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, y3, v;
  logic [3:0]    flags;
  assign in_ready  = count != CW'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // y3 is the MSB of the operand the ALU actually adds: 0, B, ~B or all-ones
  assign y3    = op[1] ? (op[0] | !b_msb) : (op[0] & b_msb);
  assign v     = (a_msb == y3) && (F[3] != a_msb);
  assign flags = {v, F[3], F == 4'b0000, Cout};
  assign {out_f, out_flags, out_op} = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {F, flags, op};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
`ifdef ARITH_RES_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_cnt <= '0;
      ovf_cnt   <= '0;
    end else begin
      if (push && Cout && carry_cnt != 8'hFF) carry_cnt <= carry_cnt + 8'd1;
      if (push && v && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_arith_result_fifo.sv
// tb_arith_result_fifo: flag vectors, fill/order/wrap sequences and random traffic against a queue model.
module tb_arith_result_fifo;
  localparam int DEPTH = 4;
  logic       clk = 0, rst = 0, in_valid = 0, out_ready = 0;
  logic [3:0] F = 0;
  logic       Cout = 0, a_msb = 0, b_msb = 0;
  logic [2:0] op = 0;
  logic       in_ready, out_valid;
  logic [3:0] out_f, out_flags;
  logic [2:0] out_op;
  logic [$clog2(DEPTH):0] count;
`ifdef ARITH_RES_STATS_EN
  logic [7:0] carry_cnt, ovf_cnt;
  int m_carry = 0, m_ovf = 0;
`endif
  int tests = 0, fails = 0;
  logic [10:0] q [$];

  arith_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .F(F), .Cout(Cout), .op(op), .a_msb(a_msb), .b_msb(b_msb),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f),
    .out_flags(out_flags), .out_op(out_op), .count(count)
`ifdef ARITH_RES_STATS_EN
    , .carry_cnt(carry_cnt), .ovf_cnt(ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] f; logic c; logic [2:0] o; logic a; logic b; logic [3:0] exp;
  } vec_t;

  function automatic void check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference flags: V is signed overflow of A + Y where the ALU's Y operand is 0, B, ~B or -1.
  function automatic logic [3:0] ref_flags(logic [3:0] f, logic c, logic [2:0] o, logic a, logic b);
    logic ymsb_tbl [4];
    logic ym, ov;
    ymsb_tbl = '{1'b0, b, ~b, 1'b1};
    ym = ymsb_tbl[o[1:0]];
    ov = (a == ym) && (f[3] != a);
    return {ov, f[3], f == 4'd0, c};
  endfunction

  task automatic cycle(output bit pu, output bit po, output logic [3:0] pf);
    logic [10:0] e;
    pu = in_valid && (q.size() < DEPTH);
    po = out_ready && (q.size() != 0);
    pf = out_f;
    if (po) begin
      e = q.pop_front();
      check("head_f", out_f, e[10:7]);
      check("head_flags", out_flags, e[6:3]);
      check("head_op", out_op, e[2:0]);
    end
    if (pu) begin
      e = {F, ref_flags(F, Cout, op, a_msb, b_msb), op};
      q.push_back(e);
`ifdef ARITH_RES_STATS_EN
      if (e[3] && m_carry < 255) m_carry++;
      if (e[6] && m_ovf < 255) m_ovf++;
`endif
    end
    @(posedge clk); #1;
    check("count", count, q.size());
    check("out_valid", out_valid, q.size() != 0);
    check("in_ready", in_ready, q.size() != DEPTH);
  endtask

  initial begin
    vec_t vecs [4];
    bit pu, po;
    logic [3:0] pf;
    int idx, popped, n;
    vecs[0] = '{4'b0101, 1'b1, 3'b001, 1'b1, 1'b1, 4'b1001};
    vecs[1] = '{4'b1101, 1'b0, 3'b110, 1'b1, 1'b1, 4'b0100};
    vecs[2] = '{4'b1000, 1'b1, 3'b011, 1'b1, 1'b1, 4'b0101};
    vecs[3] = '{4'b0000, 1'b0, 3'b000, 1'b0, 1'b0, 4'b0010};

    #2 rst = 1;
    #1;
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_f", out_f, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_out_op", out_op, 0);
    @(posedge clk); #1 rst = 0;

    // fill with the flag vectors while the consumer stalls
    for (int i = 0; i < 4; i++) begin
      {F, Cout, op, a_msb, b_msb} = {vecs[i].f, vecs[i].c, vecs[i].o, vecs[i].a, vecs[i].b};
      in_valid = 1;
      check("vec_model_flags", ref_flags(F, Cout, op, a_msb, b_msb), vecs[i].exp);
      cycle(pu, po, pf);
    end
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 0);
    F = 4'hF; Cout = 1; op = 3'b111;
    cycle(pu, po, pf);
    check("fifth_ignored", count, 4);
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check("vec_flags", out_flags, vecs[i].exp);
      check("vec_f", out_f, vecs[i].f);
      cycle(pu, po, pf);
    end
    check("drained", out_valid, 0);

    // ordering and wrap: F = 0..9 with out_ready toggling
    idx = 0; popped = 0; n = 0; out_ready = 0;
    {Cout, op, a_msb, b_msb} = 0;
    while (popped < 10 && n < 100) begin
      in_valid = idx < 10;
      F = 4'(idx);
      cycle(pu, po, pf);
      if (pu) idx++;
      if (po) begin
        check("order", pf, popped);
        popped++;
      end
      out_ready = ~out_ready;
      n++;
    end
    check("order_done", popped, 10);

    // simultaneous push and pop at count 2
    in_valid = 1; out_ready = 0;
    F = 4'hA; cycle(pu, po, pf);
    F = 4'hB; cycle(pu, po, pf);
    check("two_count", count, 2);
    F = 4'hC; out_ready = 1;
    cycle(pu, po, pf);
    check("simul_count", count, 2);
    check("simul_head", out_f, 4'hB);
    in_valid = 0;
    cycle(pu, po, pf);
    cycle(pu, po, pf);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom);
      out_ready = 1'($urandom);
      F = 4'($urandom); Cout = 1'($urandom); op = 3'($urandom);
      a_msb = 1'($urandom); b_msb = 1'($urandom);
      cycle(pu, po, pf);
    end
`ifdef ARITH_RES_STATS_EN
    check("carry_cnt", carry_cnt, m_carry);
    check("ovf_cnt", ovf_cnt, m_ovf);
`endif

    // mid-stream reset with three entries
    out_ready = 1; in_valid = 0;
    while (q.size() != 0) cycle(pu, po, pf);
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      F = 4'(i + 1); Cout = 1; op = 3'b001; a_msb = 1; b_msb = 1;
      cycle(pu, po, pf);
    end
    check("pre_rst_count", count, 3);
    rst = 1;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
`ifdef ARITH_RES_STATS_EN
    check("async_rst_carry", carry_cnt, 0);
    check("async_rst_ovf", ovf_cnt, 0);
    m_carry = 0; m_ovf = 0;
`endif
    q.delete();
    #2 rst = 0;
    F = 4'h7; Cout = 0; op = 3'b000;
    cycle(pu, po, pf);
    check("post_rst_push", count, 1);
    check("post_rst_head", out_f, 4'h7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/arith_result_fifo.md
# arith_result_fifo

Downstream capture stage for the 4-bit arithmetic circuit. It registers each result (F, Cout) with its operation code and computes the status flags carry, zero, negative and overflow. Entries are buffered in a small FIFO and presented to the consumer (accumulator/display logic) over a valid/ready handshake.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  result on F/Cout/op is valid.
- in_ready  out  1  stage can accept an entry; equals !full.
- F  in  4  arithmetic circuit result.
- Cout  in  1  arithmetic circuit carry out.
- op  in  3  {Cin, s1, s0} used for this result.
- a_msb  in  1  A[3] of the operands.
- b_msb  in  1  B[3] of the operands.
- out_valid  out  1  head entry valid; equals !empty.
- out_ready  in  1  consumer accepts head entry.
- out_f  out  4  head result.
- out_flags  out  4  {V, N, Z, C} of head.
- out_op  out  3  op of head.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Stored entry is 11 bits: F, {V,N,Z,C}, op. Flags are computed combinationally at push from the inputs:
  - C = Cout.
  - Z = (F == 4'b0000).
  - N = F[3].
  - Y3 = 0, b_msb, !b_msb, 1 for {s1,s0} = 00, 01, 10, 11.
  - V = (a_msb == Y3) && (F[3] != a_msb).
- Storage is a circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- count is tracked explicitly:
  - full = (count == DEPTH).
  - empty = (count == 0).
- Simultaneous push and pop, legal only when not empty and not full: both pointers advance and count is unchanged.
- When full, in_ready is 0, so no push occurs and nothing is dropped. A pop while full frees a slot on the next cycle.
- When empty, out_valid is 0 and out_ready is ignored. There is no bypass path from input to output.
- out_f, out_flags and out_op always reflect mem[rd_ptr]. Their value is don't-care while out_valid is 0.
- in_valid while in_ready is 0 is ignored. The upstream holds its data until accepted.

## Timing
- Reset, asynchronous, forced immediately while rst is high:
  - wr_ptr = rd_ptr = 0, count = 0.
  - out_valid = 0, in_ready = 1.
  - out_f = 0, out_flags = 0, out_op = 0 (storage is cleared).
- Assertion of rst mid-stream discards all entries. The first push after rst deasserts is accepted on the first clk edge.
- Latency: an entry pushed at edge N has out_valid = 1 after edge N (visible in cycle N+1).
- Throughput is one push and one pop per cycle. in_ready and out_valid are registered-state functions only, with no combinational path from out_ready to in_ready.
- Pop advances rd_ptr at the edge. The next entry appears in the following cycle.

## Configuration
- ARITH_RES_STATS_EN: when defined, adds two outputs:
  - carry_cnt [7:0]: counts pushes with C = 1.
  - ovf_cnt [7:0]: counts pushes with V = 1.
  - Both saturate at 8'hFF and reset to 0.
- When undefined, these ports and counters do not exist and the rest of the behaviour is identical.

## Test plan
- Reset and fill: assert rst, then push four entries with out_ready = 0.
  - After reset: count = 0, in_ready = 1, out_valid = 0.
  - After the 4th push: count = 4, in_ready = 0.
  - A 5th in_valid is ignored.
- Flags with A = 1001, B = 1100 (a_msb = 1, b_msb = 1):
  - op = 001, F = 0101, Cout = 1 gives flags = {1,0,0,1}.
  - op = 110, F = 1101, Cout = 0 gives flags = {0,1,0,0}.
  - op = 011, F = 1000, Cout = 1 gives flags = {0,1,0,1}.
- Zero flag: op = 000, F = 0000, Cout = 0 gives flags = {0,0,1,0}.
- Ordering and wrap-around: push 10 entries with F = 0..9 while out_ready toggles every cycle.
  - Outputs pop in order 0..9 with no loss or duplication.
  - Pointers wrap at least twice.
- Simultaneous push and pop at count = 2: count stays 2 and the head advances by one.
- Mid-stream reset with count = 3: asserting rst drops out_valid and count to 0 immediately, with no clock edge. With ARITH_RES_STATS_EN defined, carry_cnt and ovf_cnt also reset to 0.
